multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 64 ++++++
 rtl/multi_cycle_ctrl_decode.sv | 56 +++++
 rtl/multi_cycle_ctrl.sv | 87 ++++++++
 tb/tb_multi_cycle_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: opcodes, state encodings and control codes for the multi-cycle controller
package multi_cycle_ctrl_pkg;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010100;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  // bit 3 separates HALT from IF; both report 000 externally
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_SLT = 3'b110
  } alu_op_e;
  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JR     = 2'b10,
    PC_JUMP   = 2'b11
  } pc_src_e;
  typedef enum logic [1:0] {
    RD_RA = 2'b00,
    RD_RT = 2'b01,
    RD_RD = 2'b10
  } reg_dst_e;
  typedef enum logic [2:0] {C_ALU, C_BR, C_LS, C_JMP, C_HALT, C_NOP} op_class_e;
  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_OR, OP_SLL, OP_SLT: return C_ALU;
      OP_BEQ, OP_BNE: return C_BR;
      OP_LW, OP_SW: return C_LS;
      OP_J, OP_JR, OP_JAL: return C_JMP;
      OP_HALT: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction
  function automatic logic is_rtype(input logic [5:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR || op == OP_SLL || op == OP_SLT;
  endfunction
endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// ctrl_decode: control outputs decoded from FSM state, held opcode and ALU flags
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int RA_REG = 31
) (
  input  state_e      state,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        sign,
  output logic        pc_wre,
  output logic        ir_wre,
  output logic        reg_wre,
  output logic        m_rd,
  output logic        m_wr,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        ext_sel,
  output logic [1:0]  reg_dst,
  output logic        db_data_src,
  output logic [1:0]  pc_src,
  output logic        halted
);
  op_class_e cls;
  logic      taken;
  logic      link;
  logic      unused_sign;
  assign unused_sign = sign;
  always_comb begin
    cls         = op_class(op);
    taken       = (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
    // a link to r0 would be discarded by the register file anyway
    link        = state == S_ID && op == OP_JAL && RA_REG != 0;
    ir_wre      = state == S_IF;
    pc_wre      = (state == S_ID && (cls == C_JMP || cls == C_NOP)) || state == S_EXE_BR ||
                  (state == S_MEM && op == OP_SW) || state == S_WB_AL || state == S_WB_LD;
    reg_wre     = state == S_WB_AL || state == S_WB_LD || link;
    m_rd        = state == S_MEM && op == OP_LW;
    m_wr        = state == S_MEM && op == OP_SW;
    pc_src      = (state == S_EXE_BR && taken) ? PC_BRANCH :
                  (state == S_ID && (op == OP_J || op == OP_JAL)) ? PC_JUMP :
                  (state == S_ID && op == OP_JR) ? PC_JR : PC_NEXT;
    alu_op      = (op == OP_SUB || op == OP_BEQ || op == OP_BNE) ? ALU_SUB :
                  (op == OP_AND) ? ALU_AND :
                  (op == OP_OR || op == OP_ORI) ? ALU_OR :
                  (op == OP_SLL) ? ALU_SLL :
                  (op == OP_SLT) ? ALU_SLT : ALU_ADD;
    alu_src_a   = op == OP_SLL;
    alu_src_b   = op == OP_ADDIU || op == OP_ORI || op == OP_LW || op == OP_SW;
    ext_sel     = op != OP_ORI;
    reg_dst     = (op == OP_JAL) ? RD_RA : is_rtype(op) ? RD_RD : RD_RT;
    db_data_src = op == OP_LW;
    halted      = state == S_HALT;
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle CPU control FSM with held opcode and registered state
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int RA_REG = 31
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op_code,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic       Halted
);
  state_e     state_q, state_d;
  logic [5:0] op_q, op_d, dec_op;
  op_class_e  id_cls;
  logic       pc_wre, ir_wre, reg_wre, m_rd, m_wr, halted;
  always_comb begin
    id_cls  = op_class(Op_code);
    op_d    = (state_q == S_ID) ? Op_code : op_q;
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID:     state_d = (id_cls == C_ALU) ? S_EXE_AL :
                          (id_cls == C_BR) ? S_EXE_BR :
                          (id_cls == C_LS) ? S_EXE_LS :
                          (id_cls == C_HALT) ? S_HALT : S_IF;
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (op_q == OP_LW) ? S_WB_LD : S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
    // ID decodes the freshly loaded instruction register; later states use the held copy
    dec_op  = (state_q == S_ID) ? Op_code : op_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  ctrl_decode #(.RA_REG(RA_REG)) u_decode (
    .state       (state_q),
    .op          (dec_op),
    .zero        (zero),
    .sign        (sign),
    .pc_wre      (pc_wre),
    .ir_wre      (ir_wre),
    .reg_wre     (reg_wre),
    .m_rd        (m_rd),
    .m_wr        (m_wr),
    .alu_src_a   (ALUSrcA),
    .alu_src_b   (ALUSrcB),
    .alu_op      (ALUOp),
    .ext_sel     (ExtSel),
    .reg_dst     (RegDst),
    .db_data_src (DBDataSrc),
    .pc_src      (PCSrc),
    .halted      (halted)
  );
  always_comb begin
    state  = state_q[2:0];
    PCWre  = pc_wre & ~RST;
    IRWre  = ir_wre & ~RST;
    RegWre = reg_wre & ~RST;
    mRD    = m_rd & ~RST;
    mWR    = m_wr & ~RST;
    Halted = halted & ~RST;
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: randomized instruction stream checked against a latency-table model
module tb_multi_cycle_ctrl;
  localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_ADDIU = 6'b000010, O_AND = 6'b010000;
  localparam logic [5:0] O_ORI = 6'b010010, O_OR = 6'b010100, O_SLL = 6'b011000, O_SLT = 6'b100111;
  localparam logic [5:0] O_SW = 6'b110000, O_LW = 6'b110001, O_BEQ = 6'b110100, O_BNE = 6'b110101;
  localparam logic [5:0] O_J = 6'b111000, O_JR = 6'b111001, O_JAL = 6'b111010, O_HALT = 6'b111111;
  logic       CLK = 0, RST = 1, zero = 0, sign = 0;
  logic [5:0] Op_code = '0;
  logic [2:0] state, ALUOp;
  logic [1:0] RegDst, PCSrc;
  logic       PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, Halted;
  logic [10:0] obs;
  int n_vec = 0, n_err = 0;
  logic [5:0] ops [16] = '{O_ADD, O_SUB, O_ADDIU, O_AND, O_ORI, O_OR, O_SLL, O_SLT,
                           O_SW, O_LW, O_BEQ, O_BNE, O_J, O_JR, O_JAL, O_HALT};
  multi_cycle_ctrl #(.RA_REG(31)) dut (
    .CLK(CLK), .RST(RST), .Op_code(Op_code), .zero(zero), .sign(sign), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst),
    .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .Halted(Halted)
  );
  always #5 CLK = ~CLK;
  assign obs = {state, PCWre, IRWre, RegWre, mRD, mWR, PCSrc, Halted};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_alu(input logic [5:0] op);
    return op == O_ADD || op == O_SUB || op == O_ADDIU || op == O_AND || op == O_ORI ||
           op == O_OR || op == O_SLL || op == O_SLT;
  endfunction
  function automatic bit is_def(input logic [5:0] op);
    foreach (ops[i]) if (ops[i] == op) return 1;
    return 0;
  endfunction
  function automatic int lat(input logic [5:0] op);
    return is_alu(op) ? 4 : op == O_LW ? 5 : op == O_SW ? 4 : (op == O_BEQ || op == O_BNE) ? 3 : 2;
  endfunction
  function automatic logic [10:0] exp_ctl(input logic [5:0] op, input int c, input logic z);
    int l = lat(op);
    bit last = c == l - 1;
    bit br = op == O_BEQ || op == O_BNE;
    logic [2:0] st;
    logic [1:0] ps;
    st = c == 0 ? 3'd0 : c == 1 ? 3'd1 : is_alu(op) ? (c == 2 ? 3'd6 : 3'd7) : br ? 3'd5 :
         c == 2 ? 3'd2 : c == 3 ? 3'd3 : 3'd4;
    ps = (c == 1 && (op == O_J || op == O_JAL)) ? 2'd3 : (c == 1 && op == O_JR) ? 2'd2 :
         (br && last && ((op == O_BEQ && z) || (op == O_BNE && !z))) ? 2'd1 : 2'd0;
    return {st, last && op != O_HALT, c == 0, (last && (is_alu(op) || op == O_LW)) || (c == 1 && op == O_JAL),
            op == O_LW && c == 3, op == O_SW && c == 3, ps, 1'b0};
  endfunction
  function automatic logic [5:0] exp_alu(input logic [5:0] op);
    logic [2:0] a;
    a = (op == O_SUB || op == O_BEQ || op == O_BNE) ? 3'b001 : op == O_AND ? 3'b100 :
        (op == O_OR || op == O_ORI) ? 3'b101 : op == O_SLL ? 3'b010 : op == O_SLT ? 3'b110 : 3'b000;
    return {a, op == O_SLL, op == O_ADDIU || op == O_ORI || op == O_LW || op == O_SW, op != O_ORI};
  endfunction
  function automatic logic [1:0] exp_dst(input logic [5:0] op);
    return op == O_JAL ? 2'b00 :
           (op == O_ADD || op == O_SUB || op == O_AND || op == O_OR || op == O_SLL || op == O_SLT) ? 2'b10 : 2'b01;
  endfunction
  task automatic run_instr(input logic [5:0] op, input int zf, input int abort_at);
    int l = lat(op);
    logic [10:0] e;
    for (int c = 0; c < l; c++) begin
      Op_code = (c < 2) ? op : 6'($urandom);
      zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      sign = 1'($urandom);
      if (c == abort_at) begin
        RST = 1;
        @(negedge CLK);
        check($sformatf("abort op%b c%0d", op, c), 16'({PCWre, IRWre, RegWre, mRD, mWR, Halted}), 16'd0);
        @(posedge CLK); #1;
        RST = 0;
        return;
      end
      @(negedge CLK);
      e = exp_ctl(op, c, zero);
      check($sformatf("ctl op%b c%0d", op, c), 16'(obs), 16'(e));
      if (e[8]) check($sformatf("regdst op%b", op), 16'(RegDst), 16'(exp_dst(op)));
      if (c == l - 1 && l > 2) begin
        check($sformatf("alu op%b", op), 16'({ALUOp, ALUSrcA, ALUSrcB, ExtSel}), 16'(exp_alu(op)));
        check($sformatf("dbsrc op%b", op), 16'(DBDataSrc), 16'(op == O_LW));
      end
      @(posedge CLK); #1;
    end
  endtask
  initial begin
    logic [5:0] op;
    RST = 1;
    repeat (2) begin
      Op_code = 6'($urandom);
      @(negedge CLK);
      check("reset", 16'({PCWre, IRWre, RegWre, mRD, mWR, Halted}), 16'd0);
      @(posedge CLK); #1;
    end
    RST = 0;
    run_instr(O_ADD, -1, -1);
    run_instr(O_LW, -1, -1);
    run_instr(O_SW, -1, -1);
    run_instr(O_BEQ, 1, -1);
    run_instr(O_BEQ, 0, -1);
    run_instr(O_BNE, 0, -1);
    run_instr(O_BNE, 1, -1);
    run_instr(O_JAL, -1, -1);
    run_instr(O_J, -1, -1);
    run_instr(O_JR, -1, -1);
    run_instr(6'b101010, -1, -1);
    run_instr(O_LW, -1, 3);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (is_def(op));
      end else op = ops[$urandom_range(0, 14)];
      run_instr(op, -1, ($urandom_range(0, 19) == 0) ? $urandom_range(0, lat(op) - 1) : -1);
    end
    run_instr(O_HALT, -1, -1);
    repeat (6) begin
      Op_code = 6'($urandom);
      zero = 1'($urandom);
      @(negedge CLK);
      check("halt", 16'(obs), 16'(11'b000_00000_00_1));
      @(posedge CLK); #1;
    end
    RST = 1;
    @(negedge CLK);
    check("halt rst", 16'({PCWre, IRWre, RegWre, mRD, mWR, Halted}), 16'd0);
    @(posedge CLK); #1;
    RST = 0;
    run_instr(6'b101010, -1, -1);
    run_instr(O_ADD, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
